// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note/octave codes, tone frequency table and FSM states for tone_decoder
package tone_pkg;

   localparam logic [3:0] NOTE_SILENT = 4'd0;
   localparam logic [3:0] NOTE_DO     = 4'd1;
   localparam logic [3:0] NOTE_RE     = 4'd2;
   localparam logic [3:0] NOTE_MI     = 4'd3;
   localparam logic [3:0] NOTE_FA     = 4'd4;
   localparam logic [3:0] NOTE_SOL    = 4'd5;
   localparam logic [3:0] NOTE_LA     = 4'd6;
   localparam logic [3:0] NOTE_SI     = 4'd7;

   localparam logic [1:0] OCT_LOW  = 2'd0;
   localparam logic [1:0] OCT_MID  = 2'd1;
   localparam logic [1:0] OCT_HIGH = 2'd2;

   localparam int NUM_TONES = 21;

   // Entry i is note (i % 7) + 1 in octave i / 7.
   localparam int unsigned FREQ_HZ [NUM_TONES] = '{
      131, 147, 165, 175, 196, 220, 247,
      262, 294, 330, 349, 392, 440, 494,
      523, 587, 659, 698, 784, 880, 988
   };

   function automatic int unsigned nominal_period(input int unsigned clk_hz, input int idx);
      return clk_hz / FREQ_HZ[idx];
   endfunction

   typedef enum logic [1:0] {
      SILENT,
      ARMED,
      TRACK
   } state_t;

endpackage

// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - speaker line synchroniser, rising-edge strobe and saturating period counter
module tone_period_meter #(
   parameter int TIMEOUT_CYC = 2_000_000,
   parameter int PW          = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_speaker,
   output logic          o_strobe,
   output logic [PW-1:0] o_period,
   output logic          o_timeout
);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_sync3;
   logic          r_strobe;
   logic [PW-1:0] r_cnt;

   // Strobe is registered so it lands three cycles after the raw input rises.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync3  <= 1'b0;
         r_strobe <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= i_speaker;
         r_sync2  <= r_sync1;
         r_sync3  <= r_sync2;
         r_strobe <= r_sync2 & ~r_sync3;
         if (r_strobe)
            r_cnt <= PW'(1);
         else if (r_cnt != PW'(TIMEOUT_CYC))
            r_cnt <= r_cnt + PW'(1);
      end
   end

   assign o_strobe  = r_strobe;
   assign o_period  = r_cnt;
   assign o_timeout = (r_cnt == PW'(TIMEOUT_CYC)) && !r_strobe;

endmodule

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - recovers note/octave from the speaker square wave; TONE_DECODER_PERIOD_OUT_EN adds period_out
module tone_decoder
   import tone_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TIMEOUT_CYC = CLK_HZ / 50,
   parameter int STABLE_N    = 3,
   localparam int PW         = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          speaker_in,
   output logic [3:0]    note_out,
   output logic [1:0]    octave_out,
   output logic          note_valid,
`ifdef TONE_DECODER_PERIOD_OUT_EN
   output logic [PW-1:0] period_out,
`endif
   output logic          note_change
);

   logic          w_strobe;
   logic          w_timeout;
   logic [PW-1:0] w_period;
   logic [31:0]   w_per32;

   state_t        r_state;
   state_t        w_state_next;
   logic          w_classify;
   logic          w_enter_silent;

   logic [5:0]    w_match;
   logic [5:0]    r_cand;
   logic          r_cand_vld;
   logic [5:0]    r_prev;
   logic [3:0]    r_stab;
   logic [3:0]    w_stab_next;
   logic          w_lock;
   logic          w_clear;

   logic [3:0]    r_note;
   logic [1:0]    r_oct;
   logic          r_change;

   tone_period_meter #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .PW          (PW)
   ) u_meter (
      .i_clk     (clk),
      .i_reset_n (reset),
      .i_speaker (speaker_in),
      .o_strobe  (w_strobe),
      .o_period  (w_period),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= SILENT;
      else
         r_state <= w_state_next;
   end

   // A strobe always beats a simultaneous timeout.
   always_comb begin
      w_state_next = r_state;
      if (w_strobe) begin
         if (r_state == SILENT)
            w_state_next = ARMED;
         else
            w_state_next = TRACK;
      end else if (w_timeout) begin
         w_state_next = SILENT;
      end
   end

   assign w_classify     = w_strobe && (r_state != SILENT);
   assign w_enter_silent = (r_state != SILENT) && (w_state_next == SILENT);
   assign w_per32        = 32'(w_period);

   always_comb begin
      w_match = {NOTE_SILENT, OCT_LOW};
      for (int i = 0; i < NUM_TONES; i++) begin
         if ((w_per32 + (nominal_period(CLK_HZ, i) >> 6) >= nominal_period(CLK_HZ, i)) &&
             (w_per32 <= nominal_period(CLK_HZ, i) + (nominal_period(CLK_HZ, i) >> 6)))
            w_match = {4'(i % 7 + 1), 2'(i / 7)};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cand     <= '0;
         r_cand_vld <= 1'b0;
      end else begin
         r_cand_vld <= w_classify;
         if (w_classify)
            r_cand <= w_match;
      end
   end

   always_comb begin
      w_stab_next = r_stab;
      if (r_cand[5:2] == NOTE_SILENT)
         w_stab_next = 4'd0;
      else if (r_cand == r_prev)
         w_stab_next = (r_stab == 4'hF) ? r_stab : r_stab + 4'd1;
      else
         w_stab_next = 4'd1;
   end

   assign w_lock  = r_cand_vld && (r_cand[5:2] != NOTE_SILENT) &&
                    (w_stab_next >= 4'(STABLE_N)) && (r_cand != {r_note, r_oct});
   assign w_clear = w_timeout && ({r_note, r_oct} != 6'd0);

   // Stability history is dropped on timeout so a returning tone needs a full relock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stab <= '0;
         r_prev <= '0;
      end else if (w_enter_silent) begin
         r_stab <= '0;
         r_prev <= '0;
      end else if (r_cand_vld) begin
         r_stab <= w_stab_next;
         r_prev <= (r_cand[5:2] == NOTE_SILENT) ? 6'd0 : r_cand;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_note   <= NOTE_SILENT;
         r_oct    <= OCT_LOW;
         r_change <= 1'b0;
      end else begin
         r_change <= w_lock || w_clear;
         if (w_lock) begin
            r_note <= r_cand[5:2];
            r_oct  <= r_cand[1:0];
         end else if (w_clear) begin
            r_note <= NOTE_SILENT;
            r_oct  <= OCT_LOW;
         end
      end
   end

`ifdef TONE_DECODER_PERIOD_OUT_EN
   logic [PW-1:0] r_period_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_period_out <= '0;
      else if (w_classify)
         r_period_out <= w_period;
   end

   assign period_out = r_period_out;
`endif

   assign note_out    = r_note;
   assign octave_out  = r_oct;
   assign note_valid  = (r_note != NOTE_SILENT);
   assign note_change = r_change;

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - directed-vector bench for tone_decoder at CLK_HZ=1 MHz
module tb_tone_decoder;

   localparam int P_A4 = 2272;
   localparam int P_C4 = 3816;
   localparam int P_B4 = 2024;
   localparam int P_G5 = 1275;
   localparam int P_NO = 2400;

   logic       clk = 1'b0;
   logic       reset;
   logic       speaker_in;
   logic [3:0] note_out;
   logic [1:0] octave_out;
   logic       note_valid;
   logic       note_change;
`ifdef TONE_DECODER_PERIOD_OUT_EN
   logic [14:0] period_out;
`endif

   int n_vec = 0;
   int n_err = 0;
   int chg_cnt = 0;
   int c0;

   tone_decoder #(
      .CLK_HZ      (1_000_000),
      .TIMEOUT_CYC (20000),
      .STABLE_N    (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .speaker_in  (speaker_in),
      .note_out    (note_out),
      .octave_out  (octave_out),
      .note_valid  (note_valid),
`ifdef TONE_DECODER_PERIOD_OUT_EN
      .period_out  (period_out),
`endif
      .note_change (note_change)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (note_change === 1'b1) chg_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wave(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         speaker_in = 1'b1;
         repeat (p / 2) tick();
         speaker_in = 1'b0;
         repeat (p - p / 2) tick();
      end
   endtask

   task automatic rise_then(input int k);
      speaker_in = 1'b1;
      repeat (k) tick();
   endtask

   task automatic finish_period(input int p, input int k);
      repeat (p / 2 - k) tick();
      speaker_in = 1'b0;
      repeat (p - p / 2) tick();
   endtask

   task automatic check_note(input string tag, input int n, input int o);
      check({tag, "_note"}, 32'(note_out), 32'(n));
      check({tag, "_oct"}, 32'(octave_out), 32'(o));
      check({tag, "_valid"}, 32'(note_valid), (n != 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      reset      = 1'b0;
      speaker_in = 1'b0;
      repeat (5) tick();
      check_note("reset", 0, 0);
      check("reset_chg", 32'(note_change), 32'd0);
      reset = 1'b1;
      repeat (3) tick();

      // A4: first edge only arms, lock on the 4th edge, outputs 5 cycles later
      c0 = chg_cnt;
      wave(P_A4, 3);
      rise_then(4);
      check_note("a4_early", 0, 0);
`ifdef TONE_DECODER_PERIOD_OUT_EN
      check("a4_period_out", 32'(period_out), 32'(P_A4));
`endif
      tick();
      check_note("a4_lock", 6, 1);
      check("a4_pulse", 32'(note_change), 32'd1);
      finish_period(P_A4, 5);
      check("a4_chg_cnt", 32'(chg_cnt - c0), 32'd1);

      // C4: first C edge still measures an A4 period, lock after 3 C periods
      c0 = chg_cnt;
      wave(P_C4, 3);
      rise_then(4);
      check_note("c4_hold", 6, 1);
      tick();
      check_note("c4_lock", 1, 1);
      finish_period(P_C4, 5);
      check("c4_chg_cnt", 32'(chg_cnt - c0), 32'd1);

      // unmatched period leaves the output alone
      c0 = chg_cnt;
      wave(P_NO, 10);
      check_note("nomatch", 1, 1);
      check("nomatch_chg", 32'(chg_cnt - c0), 32'd0);

      // silence: clear 20000 cycles after the strobe of the last edge
      c0 = chg_cnt;
      speaker_in = 1'b1;
      for (int k = 1; k <= 20010; k++) begin
         tick();
         if (k == 1200) speaker_in = 1'b0;
         if (k == 20000) check("to_hold_note", 32'(note_out), 32'd1);
      end
      check_note("timeout", 0, 0);
      check("timeout_chg", 32'(chg_cnt - c0), 32'd1);
      repeat (1000) tick();
      check("silent_chg", 32'(chg_cnt - c0), 32'd1);

      // alternating A4/B4 never reaches the stability count
      c0 = chg_cnt;
      wave(P_A4, 1);
      wave(P_B4, 1);
      wave(P_A4, 1);
      wave(P_B4, 1);
      wave(P_A4, 1);
      check_note("alt", 0, 0);
      check("alt_chg", 32'(chg_cnt - c0), 32'd0);

      // G5 lock, then reset mid-lock and relock
      wave(P_G5, 3);
      rise_then(5);
      check_note("g5_lock", 5, 2);
      finish_period(P_G5, 5);
      #2;
      reset = 1'b0;
      #1;
      check_note("rst_mid", 0, 0);
      check("rst_mid_chg", 32'(note_change), 32'd0);
      repeat (3) tick();
      reset = 1'b1;
      c0 = chg_cnt;
      wave(P_G5, 3);
      rise_then(4);
      check_note("relock_early", 0, 0);
      tick();
      check_note("relock", 5, 2);
      finish_period(P_G5, 5);
      check("relock_chg", 32'(chg_cnt - c0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
Receive-side counterpart of the keyboard tone generator. It watches the square-wave speaker line and recovers the note being played: note index 1-7 (do..si) and octave 0-2, or silence. It sits beside Main as an in-system monitor and scoring source, closing the loop from the speaker back to note_out-style codes.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; nominal periods are derived from it.
TIMEOUT_CYC, CLK_HZ/50, cycles without a rising edge before silence is declared (20 ms).
STABLE_N, 3, consecutive matching periods required before the output changes (1..15).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
speaker_in  input  1  asynchronous square wave from the tone generator
note_out  output  4  0 = silence, 1..7 = do..si; 8..15 never driven
octave_out  output  2  0 low, 1 mid, 2 high; 0 while silent
note_valid  output  1  level; high iff note_out != 0
note_change  output  1  one-cycle pulse whenever {note_out, octave_out} changes

Behaviour:
- Reset (reset=0, async): all outputs 0; state SILENT; counters and synchroniser cleared.
- Input path: 2-FF synchroniser, then rising-edge detect. The edge strobe asserts 3 cycles after the input rises.
- Period counter: restarts at 1 on each edge strobe and increments every cycle. Measured period = counter value at the next strobe, i.e. cycles between strobes. The counter saturates at TIMEOUT_CYC.
- FSM:
  - SILENT: waiting for a strobe. A strobe moves to ARMED and starts the counter. This strobe is never classified.
  - ARMED: the next strobe yields the first period; go to TRACK.
  - TRACK: each strobe yields a period.
  - Any state: counter reaching TIMEOUT_CYC goes to SILENT.
- Classification, registered 1 cycle after the strobe:
  - Table of 21 nominal periods P = CLK_HZ / f (integer division).
  - f in Hz: low 131,147,165,175,196,220,247; mid 262,294,330,349,392,440,494; high 523,587,659,698,784,880,988.
  - Match iff |period - P| <= P>>6. Tolerances never overlap, so at most one entry matches.
  - No match: candidate = NONE.
- Stability:
  - A candidate equal to the previous candidate increments stab_cnt (saturating); otherwise stab_cnt = 1 and the candidate is stored.
  - NONE always clears stab_cnt to 0.
  - When stab_cnt reaches STABLE_N and the candidate differs from the current output, the outputs update on the next cycle with a one-cycle note_change.
  - Total latency from the qualifying strobe to the outputs is 2 cycles.
- Unmatched periods never alter the outputs. The last locked note is held until a new lock or timeout.
- Timeout entry to SILENT: if the outputs were non-zero, they go to 0 on the next cycle and note_change pulses once. Re-entering SILENT while already silent produces no pulse.
- Edge strobe and timeout in the same cycle: the strobe wins. The counter restarts, the period (= TIMEOUT_CYC) is classified and will not match.
- Octave changes alone (same note, different octave) count as a change.
- Reset asserted mid-measurement aborts everything immediately. After release, the block behaves as after power-up.

Optional Feature:
TONE_DECODER_PERIOD_OUT_EN
- Defined: adds output period_out [PW-1:0], with PW = $clog2(TIMEOUT_CYC+1). It carries the last measured period, updated 1 cycle after each strobe in ARMED/TRACK, and resets to 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package tone_pkg holds:
  - note code constants (NOTE_SILENT=0, NOTE_DO=1..NOTE_SI=7);
  - octave codes;
  - the 21-entry frequency table;
  - function nominal_period(clk_hz, idx);
  - the FSM state typedef {SILENT, ARMED, TRACK}.
- One sub-module, tone_period_meter: synchroniser, edge detect, saturating counter and timeout. It outputs a period strobe, a period value and a timeout flag. Classification, stability and FSM stay in tone_decoder.

Test Plan:
Bench parameters: CLK_HZ=1_000_000, TIMEOUT_CYC=20000, STABLE_N=3. A4 nominal = 2272, tolerance 35.
1. Square wave with period 2272 cycles (A4) -> after the 4th rising edge plus 5 cycles: note_out=6, octave_out=1, note_valid=1, one note_change pulse.
2. Switch to period 3816 (C4) -> after 3 matching periods: note_out=1, octave_out=1, exactly one note_change. Outputs hold 6/1 until then.
3. Period 2400 (no match) for 10 cycles of the wave -> outputs remain at the previous note, no note_change.
4. Stop toggling -> 20000 cycles after the last edge: note_out=0, octave_out=0, note_valid=0, one pulse. Continued silence gives no further pulses.
5. Alternate the periods 2272 and 2024 every edge -> the stability count never reaches 3, and the outputs never change.
6. Assert reset while locked on 5/2 (period 1275) -> all outputs 0 immediately. After release with the input still toggling, relock after 4 edges.
